// File: rtl/ccd_capture_pkg.sv
// Shared types and default geometry for the CCD capture front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ccd_capture_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_CNT_W    = 11;
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_FCNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } capState_t;

endpackage

// File: rtl/ccd_xy_counter.sv
// Column/row tracker for incoming pixels: clear on frame start, step per pixel, realign on short lines.
// Latency: oX/oY are combinational (count before this pixel's increment); state updates next edge.
// Backpressure: none; follows the sensor stream every cycle.
module ccd_xy_counter
  import ccd_capture_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iClr,
  input  logic             iInc,
  input  logic             iRealign,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] xCnt, yCnt, xNext, yNext, yStep;

  // Current coordinate (frame-start clear applies to the pixel arriving with it) and next count.
  always_comb begin
    oX    = iClr ? '0 : xCnt;
    oY    = iClr ? '0 : yCnt;
    yStep = (oY == Y_LAST) ? '0 : oY + CNT_W'(1);
    xNext = oX;
    yNext = oY;
    if (iInc) begin
      if (oX == X_LAST) begin
        xNext = '0;
        yNext = yStep;
      end else begin
        xNext = oX + CNT_W'(1);
      end
    end else if (iRealign && (oX != '0)) begin
      // Line ended early: start the next line at column 0 of the following row.
      xNext = '0;
      yNext = yStep;
    end
  end

  // Counter state register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      xCnt <= '0;
      yCnt <= '0;
    end else begin
      xCnt <= xNext;
      yCnt <= yNext;
    end
  end

endmodule

// File: rtl/ccd_capture_ctrl.sv
// Sensor front end: frames FVAL/LVAL pixels into DVAL+X/Y under start/stop control, counts frames.
// Latency: 2 cycles from iDATA/iFVAL/iLVAL to oDATA/oDVAL/oX_Cont/oY_Cont.
// Backpressure: none; the sensor cannot be stalled, so every valid pixel is forwarded.
module ccd_capture_ctrl
  import ccd_capture_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int FCNT_W   = DEF_FCNT_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont,
  output logic [FCNT_W-1:0] oFrame_Cont,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oBusy
);

  logic [DATA_W-1:0] rD;
  logic              rF, rL, rF_d, rL_d;
  logic              fvRise, fvFall, lvFall, pixIn, pixVld, sofNow, frameEnd;
  logic              stopReq, sofPend;
  logic [CNT_W-1:0]  xCur, yCur;
  capState_t         state, nextState;

  // Stage 1: register the raw sensor bus and keep one cycle of framing history.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rD   <= '0;
      rF   <= 1'b0;
      rL   <= 1'b0;
      rF_d <= 1'b0;
      rL_d <= 1'b0;
    end else begin
      rD   <= iDATA;
      rF   <= iFVAL;
      rL   <= iLVAL;
      rF_d <= rF;
      rL_d <= rL;
    end
  end

  assign fvRise = rF & ~rF_d;
  assign fvFall = ~rF & rF_d;
  assign lvFall = ~rL & rL_d;
  assign pixIn  = rF & rL;

  // Capture FSM: iEND beats iSTART; arming mid-frame waits for the next frame start.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (iSTART && !iEND) nextState = ARMED;
      ARMED:   if (iEND) nextState = IDLE;
               else if (fvRise) nextState = ACTIVE;
      ACTIVE:  if (fvFall && (stopReq || iEND)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pixels pass while ACTIVE and on the ARMED->ACTIVE cycle; SOF marks the first of each frame.
  assign pixVld   = pixIn & ((state == ACTIVE) | (nextState == ACTIVE));
  assign sofNow   = pixVld & (fvRise | sofPend);
  assign frameEnd = fvFall & (state == ACTIVE);

  // State register plus pending stop and pending-SOF flags.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= IDLE;
      stopReq <= 1'b0;
      sofPend <= 1'b0;
    end else begin
      state   <= nextState;
      stopReq <= (state == ACTIVE) && (nextState == ACTIVE) && (stopReq || iEND);
      sofPend <= (fvRise | sofPend) & rF & ~pixVld;
    end
  end

  ccd_xy_counter #(
    .CNT_W    (CNT_W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) uXy (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClr     (fvRise),
    .iInc     (pixIn),
    .iRealign (lvFall),
    .oX       (xCur),
    .oY       (yCur)
  );

  // Stage 2: registered outputs; pixel fields hold their last value between valid pixels.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oSOF        <= 1'b0;
      oEOF        <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      oDVAL <= pixVld;
      oSOF  <= sofNow;
      oEOF  <= frameEnd;
      oBusy <= (nextState != IDLE);
      if (pixVld) begin
        oDATA   <= rD;
        oX_Cont <= xCur;
        oY_Cont <= yCur;
      end
      if (frameEnd) oFrame_Cont <= oFrame_Cont + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// Directed bench for ccd_capture_ctrl on an 8x4 frame geometry.
// Latency: inputs driven on falling edges, outputs sampled 1 time unit after rising edges.
// Backpressure: n/a.
module tb_ccd_capture_ctrl;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 11;
  localparam int H      = 8;
  localparam int V      = 4;
  localparam int FCNT_W = 32;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b0;
  logic [DATA_W-1:0] iDATA = '0;
  logic              iFVAL = 1'b0, iLVAL = 1'b0, iSTART = 1'b0, iEND = 1'b0;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL, oSOF, oEOF, oBusy;
  logic [CNT_W-1:0]  oX_Cont, oY_Cont;
  logic [FCNT_W-1:0] oFrame_Cont;

  always #5 iCLK = ~iCLK;

  ccd_capture_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .H_ACTIVE(H), .V_ACTIVE(V), .FCNT_W(FCNT_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oSOF(oSOF), .oEOF(oEOF), .oBusy(oBusy)
  );

  int total = 0;
  int bad   = 0;
  int edgeCnt = 0;
  int firstDrvEdge = 0;
  int sofCnt = 0;
  int eofCnt = 0;
  int capData[$];
  int capX[$];
  int capY[$];
  int capSof[$];
  int capEdge[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: log every valid output pixel and count SOF/EOF pulses.
  always @(posedge iCLK) begin
    edgeCnt++;
    #1;
    if (oDVAL === 1'b1) begin
      capData.push_back(int'(oDATA));
      capX.push_back(int'(oX_Cont));
      capY.push_back(int'(oY_Cont));
      capSof.push_back(int'(oSOF));
      capEdge.push_back(edgeCnt);
    end
    if (oSOF === 1'b1) sofCnt++;
    if (oEOF === 1'b1) eofCnt++;
  end

  task automatic clearCap();
    capData.delete(); capX.delete(); capY.delete(); capSof.delete(); capEdge.delete();
    sofCnt = 0;
    eofCnt = 0;
  endtask

  task automatic resetDut();
    @(negedge iCLK);
    iRST = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0; iDATA = '0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic pulse(input logic s, input logic e);
    @(negedge iCLK);
    iSTART = s; iEND = e;
    @(negedge iCLK);
    iSTART = 1'b0; iEND = 1'b0;
  endtask

  // One frame: FVAL and LVAL rise together, 2-cycle line gaps, optional short line and
  // optional iSTART/iEND pulse in the gap before a chosen line. Pixel n carries value n.
  task automatic sendFrame(input int nLines, input int shortLine, input int startLine, input int endLine);
    int n;
    int len;
    n = 0;
    for (int ln = 0; ln < nLines; ln++) begin
      if (ln > 0) begin
        @(negedge iCLK);
        iFVAL = 1'b1; iLVAL = 1'b0;
        iSTART = (ln == startLine);
        iEND   = (ln == endLine);
        @(negedge iCLK);
        iSTART = 1'b0; iEND = 1'b0;
      end
      len = (ln == shortLine) ? 5 : H;
      for (int p = 0; p < len; p++) begin
        @(negedge iCLK);
        if (n == 0) firstDrvEdge = edgeCnt;
        iFVAL = 1'b1; iLVAL = 1'b1; iDATA = DATA_W'(n);
        n++;
      end
    end
    @(negedge iCLK);
    iLVAL = 1'b0;
    repeat (5) begin
      @(negedge iCLK);
      iFVAL = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last;
    // Test 1: reset state, then a frame with no iSTART.
    resetDut();
    chk("rst dval", oDVAL, 0);
    chk("rst data", oDATA, 0);
    chk("rst x", oX_Cont, 0);
    chk("rst y", oY_Cont, 0);
    chk("rst frame", oFrame_Cont, 0);
    chk("rst busy", oBusy, 0);
    chk("rst sof", oSOF, 0);
    chk("rst eof", oEOF, 0);
    clearCap();
    sendFrame(V, -1, -1, -1);
    chk("t1 dval count", capData.size(), 0);
    chk("t1 busy", oBusy, 0);
    chk("t1 frame", oFrame_Cont, 0);

    // Test 2: armed, one full frame.
    resetDut();
    clearCap();
    pulse(1'b1, 1'b0);
    chk("t2 busy armed", oBusy, 1);
    sendFrame(V, -1, -1, -1);
    chk("t2 dval count", capData.size(), H * V);
    if (capEdge.size() > 0) chk("t2 latency", capEdge[0] - firstDrvEdge, 2);
    for (int i = 0; i < capData.size() && i < H * V; i++) begin
      chk($sformatf("t2 data[%0d]", i), capData[i], i);
      chk($sformatf("t2 x[%0d]", i), capX[i], i % H);
      chk($sformatf("t2 y[%0d]", i), capY[i], i / H);
    end
    if (capSof.size() > 0) chk("t2 sof first", capSof[0], 1);
    chk("t2 sof count", sofCnt, 1);
    chk("t2 eof count", eofCnt, 1);
    chk("t2 frame", oFrame_Cont, 1);
    chk("t2 data hold", oDATA, H * V - 1);
    chk("t2 dval idle", oDVAL, 0);
    chk("t2 busy", oBusy, 1);

    // Test 3: iSTART while FVAL already high waits for the next frame.
    resetDut();
    clearCap();
    sendFrame(V, -1, 2, -1);
    chk("t3 partial dval", capData.size(), 0);
    chk("t3 busy armed", oBusy, 1);
    chk("t3 frame none", oFrame_Cont, 0);
    sendFrame(V, -1, -1, -1);
    chk("t3 dval count", capData.size(), H * V);
    if (capData.size() == H * V) begin
      last = H * V - 1;
      chk("t3 first data", capData[0], 0);
      chk("t3 first x", capX[0], 0);
      chk("t3 first y", capY[0], 0);
      chk("t3 last data", capData[last], last);
      chk("t3 last x", capX[last], H - 1);
      chk("t3 last y", capY[last], V - 1);
    end
    chk("t3 sof count", sofCnt, 1);
    chk("t3 frame", oFrame_Cont, 1);

    // Test 4: iEND during frame 2 completes it, then returns to IDLE.
    resetDut();
    clearCap();
    pulse(1'b1, 1'b0);
    sendFrame(V, -1, -1, -1);
    chk("t4 frame1", oFrame_Cont, 1);
    chk("t4 busy1", oBusy, 1);
    sendFrame(V, -1, -1, 1);
    chk("t4 frame2", oFrame_Cont, 2);
    chk("t4 dval count2", capData.size(), 2 * H * V);
    chk("t4 eof count", eofCnt, 2);
    chk("t4 busy idle", oBusy, 0);
    sendFrame(V, -1, -1, -1);
    chk("t4 dval count3", capData.size(), 2 * H * V);
    chk("t4 frame3", oFrame_Cont, 2);

    // Test 5: short line realign and Y wrap over 9 lines.
    resetDut();
    clearCap();
    pulse(1'b1, 1'b0);
    sendFrame(9, 1, -1, -1);
    chk("t5 dval count", capData.size(), 69);
    if (capData.size() >= 69) begin
      chk("t5 short start x", capX[8], 0);
      chk("t5 short start y", capY[8], 1);
      chk("t5 short end x", capX[12], 4);
      chk("t5 realign x", capX[13], 0);
      chk("t5 realign y", capY[13], 2);
      chk("t5 wrap x", capX[29], 0);
      chk("t5 wrap y", capY[29], 0);
      chk("t5 wrap sof", capSof[29], 0);
      chk("t5 last x", capX[68], 7);
      chk("t5 last y", capY[68], 0);
      chk("t5 last data", capData[68], 68);
    end
    chk("t5 sof count", sofCnt, 1);
    chk("t5 frame", oFrame_Cont, 1);

    // Test 6: reset mid-frame at pixel 13, then no capture until a clean iSTART.
    resetDut();
    clearCap();
    pulse(1'b1, 1'b0);
    for (int p = 0; p < 8; p++) begin
      @(negedge iCLK);
      iFVAL = 1'b1; iLVAL = 1'b1; iDATA = DATA_W'(p);
    end
    repeat (2) begin
      @(negedge iCLK);
      iLVAL = 1'b0;
    end
    for (int p = 8; p < 13; p++) begin
      @(negedge iCLK);
      iLVAL = 1'b1; iDATA = DATA_W'(p);
    end
    chk("t6 pre dval", oDVAL, 1);
    chk("t6 pre busy", oBusy, 1);
    @(negedge iCLK);
    iDATA = DATA_W'(13); iRST = 1'b0;
    #1;
    chk("t6 rst dval", oDVAL, 0);
    chk("t6 rst data", oDATA, 0);
    chk("t6 rst x", oX_Cont, 0);
    chk("t6 rst y", oY_Cont, 0);
    chk("t6 rst busy", oBusy, 0);
    chk("t6 rst sof", oSOF, 0);
    clearCap();
    for (int p = 14; p < 16; p++) begin
      @(negedge iCLK);
      iDATA = DATA_W'(p);
    end
    @(negedge iCLK);
    iLVAL = 1'b0; iRST = 1'b1;
    for (int ln = 2; ln < V; ln++) begin
      @(negedge iCLK);
      iLVAL = 1'b0;
      for (int p = 0; p < H; p++) begin
        @(negedge iCLK);
        iLVAL = 1'b1; iDATA = DATA_W'(ln * H + p);
      end
    end
    @(negedge iCLK);
    iLVAL = 1'b0;
    repeat (5) begin
      @(negedge iCLK);
      iFVAL = 1'b0;
    end
    chk("t6 after rst dval", capData.size(), 0);
    chk("t6 after rst busy", oBusy, 0);
    sendFrame(V, -1, -1, -1);
    chk("t6 no start dval", capData.size(), 0);
    pulse(1'b1, 1'b1);
    chk("t6 start+end busy", oBusy, 0);
    sendFrame(V, -1, -1, -1);
    chk("t6 start+end dval", capData.size(), 0);
    chk("t6 frame", oFrame_Cont, 0);
    chk("t6 eof count", eofCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
